// File: rtl/pipelined_shifter_if.sv
// Request/response bundle for the pipelined barrel shifter.
//
// Handshake: on both the request side (in_valid/in_ready) and the result
// side (out_valid/out_ready), a transfer happens on a rising clock edge
// exactly when valid and ready are both high. A producer holding valid
// keeps its payload stable until the transfer. Valid never waits on ready.
interface pipelined_shifter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  localparam int AMT_W = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [DATA_WIDTH-1:0] in_data;
  logic [AMT_W-1:0]      in_amount;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_carry;
  logic                  out_zero;
  logic                  out_illegal;
  logic [TAG_WIDTH-1:0]  out_tag;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_op, in_data, in_amount, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_op, in_data, in_amount, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator. Shift level k moves the operand by 2^k;
// levels are grouped LEVELS_PER_STAGE at a time into registered stages with
// bubble-collapsing valid/ready flow. Carry is tracked per applied level so
// the last applied level leaves the architecturally defined carry bit.
module pipelined_shifter #(
  parameter int DATA_WIDTH       = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_shifter_if.slave   bus
);
  localparam int AMT_W      = $clog2(DATA_WIDTH);
  localparam int PIPE_DEPTH = (AMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            op;
    logic [AMT_W-1:0]      amt;
    logic                  fill;
    logic                  carry;
    logic [TAG_WIDTH-1:0]  tag;
  } payload_t;

  // One shift level. Levels whose amount bit is clear leave data and carry
  // untouched, so the carry seen at the end comes from the last applied
  // level; for rotates that is the final result bit. Reserved ops pass through.
  function automatic payload_t apply_level(input payload_t p, input int k);
    payload_t              r;
    int                    sh;
    logic [DATA_WIDTH-1:0] d;
    r  = p;
    sh = 1 << k;
    d  = p.data;
    if (p.amt[k]) begin
      case (p.op)
        OP_LSL: begin
          r.carry = d[DATA_WIDTH-sh];
          r.data  = d << sh;
        end
        OP_LSR: begin
          r.carry = d[sh-1];
          r.data  = d >> sh;
        end
        OP_ASR: begin
          r.carry = d[sh-1];
          r.data  = p.fill ? ~((~d) >> sh) : (d >> sh);
        end
        OP_ROL: begin
          r.data  = (d << sh) | (d >> (DATA_WIDTH - sh));
          r.carry = r.data[0];
        end
        OP_ROR: begin
          r.data  = (d >> sh) | (d << (DATA_WIDTH - sh));
          r.carry = r.data[DATA_WIDTH-1];
        end
        default: r = p;
      endcase
    end
    return r;
  endfunction

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [PIPE_DEPTH-1:0] up_valid;
  logic [PIPE_DEPTH-1:0] stage_rdy;
  logic [PIPE_DEPTH-1:0] load;
  payload_t              entry;
  payload_t              last_res;
  payload_t              last_q;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;

  // Capture the request: ASR fill bit is taken from the operand's MSB here.
  always_comb begin
    entry       = '0;
    entry.data  = bus.in_data;
    entry.op    = bus.in_op;
    entry.amt   = bus.in_amount;
    entry.fill  = bus.in_data[DATA_WIDTH-1];
    entry.carry = 1'b0;
    entry.tag   = bus.in_tag;
  end

  // Backward ready chain: a stage can load when empty or when it drains this cycle.
  always_comb begin
    logic down;
    stage_rdy = '0;
    load      = '0;
    valid_d   = valid_q;
    up_valid  = valid_q << 1;
    up_valid[0] = bus.in_valid;
    down = bus.out_ready;
    for (int s = PIPE_DEPTH - 1; s >= 0; s--) begin
      stage_rdy[s] = ~valid_q[s] | down;
      down         = stage_rdy[s];
    end
    for (int s = 0; s < PIPE_DEPTH; s++) begin
      load[s]    = stage_rdy[s] & up_valid[s];
      valid_d[s] = stage_rdy[s] ? up_valid[s] : valid_q[s];
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI = ((s + 1) * LEVELS_PER_STAGE > AMT_W) ? AMT_W : (s + 1) * LEVELS_PER_STAGE;

    payload_t src;
    payload_t res;
    payload_t pl_q, pl_d;

    if (s == 0) begin : g_head
      assign src = entry;
    end else begin : g_body
      assign src = g_stage[s-1].pl_q;
    end

    // Apply this stage's share of the shift levels in ascending order.
    always_comb begin
      res = src;
      for (int k = LO; k < HI; k++) res = apply_level(res, k);
    end

    // Payload only moves on a load; a stalled stage holds its contents.
    always_comb begin
      pl_d = pl_q;
      if (load[s]) pl_d = res;
    end

    // Stage payload register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pl_q <= '0;
      else        pl_q <= pl_d;
    end
  end

  assign last_res = g_stage[PIPE_DEPTH-1].res;
  assign last_q   = g_stage[PIPE_DEPTH-1].pl_q;

  // Result flags are computed as the final stage loads.
  always_comb begin
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (load[PIPE_DEPTH-1]) begin
      zero_d    = (last_res.data == '0);
      illegal_d = (last_res.op > OP_ROR);
    end
  end

  // Final-stage flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  logic unused_last;
  assign unused_last = ^{last_q.op, last_q.amt, last_q.fill};

  assign bus.in_ready    = stage_rdy[0];
  assign bus.out_valid   = valid_q[PIPE_DEPTH-1];
  assign bus.out_data    = last_q.data;
  assign bus.out_carry   = last_q.carry;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_tag     = last_q.tag;
endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter/rotator for the integer execute path. Performs logical left, logical right, arithmetic right, rotate left and rotate right on a DATA_WIDTH-bit operand. The log2(DATA_WIDTH) shift levels are split across registered pipeline stages with valid/ready flow control at both ends. It also produces carry-out and zero flags plus an opaque sideband tag, so results can retire out of the ALU without a separate lookup.

## Interface
- DATA_WIDTH, 32: operand width; power of two, 8..64.
- LEVELS_PER_STAGE, 2: shift levels per pipeline stage, 1..log2(DATA_WIDTH). PIPE_DEPTH = ceil(log2(DATA_WIDTH)/LEVELS_PER_STAGE). AMT_W = log2(DATA_WIDTH).
- TAG_WIDTH, 4: width of the sideband tag, ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage 0 can accept this cycle.
- in_op  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved.
- in_data  in  DATA_WIDTH  operand.
- in_amount  in  AMT_W  shift count; always taken modulo DATA_WIDTH.
- in_tag  in  TAG_WIDTH  sideband value, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  DATA_WIDTH  result.
- out_carry  out  1  carry flag (see Operation).
- out_zero  out  1  set when out_data == 0.
- out_illegal  out  1  set when the op was reserved.
- out_tag  out  TAG_WIDTH  tag of the result.

## Operation
- Level k shifts or rotates by 2^k when in_amount[k]=1. Levels 0..AMT_W-1 are applied in ascending order. Stage s holds levels s*LEVELS_PER_STAGE .. min((s+1)*LEVELS_PER_STAGE, AMT_W)-1.
- Fill bits: LSL and LSR fill with 0. ASR fills with in_data[DATA_WIDTH-1], captured at entry and carried down the pipe. Rotates wrap bits around.
- out_carry, for amount n ≠ 0:
  - LSL: in_data[DATA_WIDTH-n].
  - LSR and ASR: in_data[n-1].
  - ROL: out_data[0].
  - ROR: out_data[DATA_WIDTH-1].
  - When n = 0, out_carry = 0 for every op.
- Reserved op: out_data = in_data, out_carry = 0, out_illegal = 1. out_zero is still computed from out_data.
- out_zero and out_illegal are registered with the final stage. They are never combinational from the inputs.
- Each stage holds a valid bit and a payload (data, op, residual amount, fill bit, carry, tag).
- Bubble-collapsing flow. Stage s loads from s-1 when !valid[s], or when stage s is advancing this cycle. The last stage advances when out_ready=1.
- in_ready = !valid[0] OR stage 0 advancing. This is a combinational path from out_ready through the stage valids.
- A transfer occurs only when valid and ready are both high on the same edge. Payload registers update only on load, never while stalled.

## Timing
- Latency: a request accepted on edge T appears with out_valid=1 after edge T+PIPE_DEPTH-1, i.e. in cycle T+PIPE_DEPTH counting the acceptance cycle as 1. This holds when there is no backpressure.
- Throughput: one request per cycle while out_ready=1.
- Stall: out_valid=1 with out_ready=0 holds all out_* stable. Upstream stages keep filling until every stage is valid, then in_ready=0.
- Simultaneous last-stage drain and stage-0 load on a full pipe: both occur on the same edge, with no bubble and no loss.
- Reset (rst_n=0, any time):
  - All valid bits clear immediately, so out_valid=0 and in_ready=1 once reset is released.
  - out_data=0, out_carry=0, out_zero=0, out_illegal=0, out_tag=0.
  - In-flight requests are discarded. There is no partial result.
- PIPE_DEPTH=1 degenerates to one registered stage with full throughput.

## Test plan
Unless stated, parameters are DATA_WIDTH=32, LEVELS_PER_STAGE=2, so PIPE_DEPTH=3.
- Basic ops, out_ready tied high. Each result appears 3 cycles after acceptance:
  - LSL 0x8000_0001 by 1 -> data 0x0000_0002, carry 1.
  - ASR 0x8000_0000 by 31 -> data 0xFFFF_FFFF, carry 0.
  - ROR 0x0000_0001 by 1 -> data 0x8000_0000, carry 1.
- Amount 0 and zero flag:
  - LSR 0x1234_5678 by 0 -> data unchanged, carry 0, zero 0.
  - LSR 0x0000_0001 by 1 -> data 0, carry 1, zero 1.
- Reserved op 6 on 0xDEAD_BEEF, tag 0x5 -> data 0xDEAD_BEEF, illegal 1, tag 0x5.
- Backpressure: stream tags 0..7 back to back, hold out_ready=0 for 5 cycles, then release.
  - in_ready drops after 3 accepts.
  - Outputs stay stable while stalled.
  - Tags emerge 0..7 in order with no duplicates or gaps.
- Reset mid-stream: assert rst_n=0 with 3 requests in flight.
  - Immediately: out_valid=0 and all out_* = 0.
  - After release: in_ready=1, and no stale result ever appears.
- Parameter sweep (DATA_WIDTH 8/16/64, LEVELS_PER_STAGE 1..AMT_W): random ops compared against a behavioural model.
  - Latency equals PIPE_DEPTH in every configuration.
  - ROL by n equals ROR by DATA_WIDTH-n.
